// File: rtl/aes128_core.sv
// Iterative AES-128 engine: one round per clock, free-running LOAD/ROUND/DONE.
// DECRYPT selects the inverse cipher; its key input is then the round-10 key.
module aes128_core #(
  parameter bit DECRYPT = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] data_in,
  input  logic [127:0] key,
  output logic [127:0] data_out,
  output logic         finished
);

  localparam logic [1:0] S_LOAD  = 2'd0;
  localparam logic [1:0] S_ROUND = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]   fsm;
  logic [3:0]   cnt;
  logic [3:0]   rc_idx;
  logic [127:0] st;
  logic [127:0] rk;
  logic [127:0] rk_nxt;
  logic [127:0] st_nxt;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // Field inverse as a^254 (maps 0 to 0, as the S-box requires)
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] y;
    logic [7:0] r;
    y = gmul(a, a);
    r = y;
    for (int i = 0; i < 6; i++) begin
      y = gmul(y, y);
      r = gmul(r, y);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] v);
    logic [7:0] a;
    a = ginv(v);
    return a ^ {a[6:0], a[7]} ^ {a[5:0], a[7:6]}
             ^ {a[4:0], a[7:5]} ^ {a[3:0], a[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] isbox(input logic [7:0] a);
    return ginv({a[6:0], a[7]} ^ {a[4:0], a[7:5]}
              ^ {a[1:0], a[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [31:0] subrot(input logic [31:0] w);
    return {sbox(w[23:16]), sbox(w[15:8]),
            sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  // Byte n of the state sits at bits [127-8n -: 8]; n = row + 4*col
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = sbox(s[127-8*(r+4*((c+r)%4)) -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = isbox(s[127-8*(r+4*((c+4-r)%4)) -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] s,
                                       input logic inv);
    logic [127:0] o;
    logic [7:0]   cf [4];
    logic [7:0]   b;
    o = '0;
    if (inv) begin
      cf[0] = 8'd14; cf[1] = 8'd11; cf[2] = 8'd13; cf[3] = 8'd9;
    end else begin
      cf[0] = 8'd2;  cf[1] = 8'd3;  cf[2] = 8'd1;  cf[3] = 8'd1;
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        b = '0;
        for (int j = 0; j < 4; j++)
          b = b ^ gmul(s[127-8*(j+4*c) -: 8], cf[(j-r+4)%4]);
        o[127-8*(r+4*c) -: 8] = b;
      end
    return o;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  assign rc_idx = DECRYPT ? 4'd11 - cnt : cnt;

  always_comb begin
    logic [31:0] w0, w1, w2, w3, t, p3;
    logic [127:0] a;
    w0 = rk[127:96];
    w1 = rk[95:64];
    w2 = rk[63:32];
    w3 = rk[31:0];
    rk_nxt = '0;
    st_nxt = '0;
    t = '0;
    p3 = '0;
    a = '0;
    if (DECRYPT) begin
      p3 = w3 ^ w2;
      rk_nxt[127:96] = w0 ^ subrot(p3) ^ {rcon(rc_idx), 24'h0};
      rk_nxt[95:0]   = {w1 ^ w0, w2 ^ w1, p3};
      a = inv_sub_shift(st) ^ rk_nxt;
      st_nxt = (cnt == 4'd10) ? a : mix(a, 1'b1);
    end else begin
      t = w0 ^ subrot(w3) ^ {rcon(rc_idx), 24'h0};
      rk_nxt = {t, t ^ w1, t ^ w1 ^ w2, t ^ w1 ^ w2 ^ w3};
      a = sub_shift(st);
      st_nxt = ((cnt == 4'd10) ? a : mix(a, 1'b0)) ^ rk_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      fsm      <= S_LOAD;
      cnt      <= '0;
      st       <= '0;
      rk       <= '0;
      data_out <= '0;
      finished <= 1'b0;
    end else begin
      finished <= 1'b0;
      case (fsm)
        S_LOAD: begin
          st  <= data_in ^ key;
          rk  <= key;
          cnt <= 4'd1;
          fsm <= S_ROUND;
        end
        S_ROUND: begin
          st  <= st_nxt;
          rk  <= rk_nxt;
          cnt <= cnt + 4'd1;
          if (cnt == 4'd10) fsm <= S_DONE;
        end
        S_DONE: begin
          data_out <= st;
          finished <= 1'b1;
          fsm      <= S_LOAD;
        end
        default: fsm <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_aes128_core.sv
// Scoreboard bench for aes128_core: one cipher and one inverse-cipher
// instance run side by side from FIPS-197 vectors.
module tb_aes128_core;

  localparam int N = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] ed, ek, dd, dk;
  logic [127:0] eo, dout;
  logic         ef, df;

  always #5 clk = ~clk;

  aes128_core #(.DECRYPT(1'b0)) u_enc (
    .clk(clk), .rst_n(rst), .data_in(ed), .key(ek),
    .data_out(eo), .finished(ef)
  );

  aes128_core #(.DECRYPT(1'b1)) u_dec (
    .clk(clk), .rst_n(rst), .data_in(dd), .key(dk),
    .data_out(dout), .finished(df)
  );

  int checks = 0;
  int errors = 0;
  int ecount;
  logic [127:0] eq[$];
  logic [127:0] dq[$];
  logic [127:0] v_ed[N], v_ek[N], v_ex[N];
  logic [127:0] v_dd[N], v_dk[N], v_dx[N];

  always @(posedge clk or posedge rst)
    if (rst) ecount <= 0;
    else     ecount <= ecount + 1;

  logic [127:0] elast, eexp;
  logic         eprev;
  always @(negedge clk) begin
    if (rst) begin
      elast = '0;
      eprev = 1'b0;
    end else begin
      if (ef) begin
        checks++;
        if (eprev) begin
          errors++; $display("FAIL enc_pulse_width two cycles high");
        end
        checks++;
        if (ecount % 12 != 0) begin
          errors++; $display("FAIL enc_timing edge %0d, want multiple of 12", ecount);
        end
        checks++;
        if (eq.size() == 0) begin
          errors++; $display("FAIL enc_unexpected finished with empty queue");
        end else begin
          eexp = eq.pop_front();
          if (eo !== eexp) begin
            errors++; $display("FAIL enc_data got %h want %h", eo, eexp);
          end
          elast = eexp;
        end
      end else begin
        checks++;
        if (eo !== elast) begin
          errors++; $display("FAIL enc_hold got %h want %h", eo, elast);
        end
      end
      eprev = ef;
    end
  end

  logic [127:0] dlast, dexp;
  logic         dprev;
  always @(negedge clk) begin
    if (rst) begin
      dlast = '0;
      dprev = 1'b0;
    end else begin
      if (df) begin
        checks++;
        if (dprev) begin
          errors++; $display("FAIL dec_pulse_width two cycles high");
        end
        checks++;
        if (ecount % 12 != 0) begin
          errors++; $display("FAIL dec_timing edge %0d, want multiple of 12", ecount);
        end
        checks++;
        if (dq.size() == 0) begin
          errors++; $display("FAIL dec_unexpected finished with empty queue");
        end else begin
          dexp = dq.pop_front();
          if (dout !== dexp) begin
            errors++; $display("FAIL dec_data got %h want %h", dout, dexp);
          end
          dlast = dexp;
        end
      end else begin
        checks++;
        if (dout !== dlast) begin
          errors++; $display("FAIL dec_hold got %h want %h", dout, dlast);
        end
      end
      dprev = df;
    end
  end

  task automatic check_reset(input string nm);
    checks++;
    if (eo !== '0 || ef !== 1'b0) begin
      errors++;
      $display("FAIL %s_enc got %h/%b want 0/0", nm, eo, ef);
    end
    checks++;
    if (dout !== '0 || df !== 1'b0) begin
      errors++;
      $display("FAIL %s_dec got %h/%b want 0/0", nm, dout, df);
    end
  endtask

  task automatic apply(input int k);
    ed = v_ed[k]; ek = v_ek[k]; eq.push_back(v_ex[k]);
    dd = v_dd[k]; dk = v_dk[k]; dq.push_back(v_dx[k]);
  endtask

  initial begin
    v_ed[0] = 128'h00112233445566778899aabbccddeeff;
    v_ek[0] = 128'h000102030405060708090a0b0c0d0e0f;
    v_ex[0] = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    v_ed[2] = 128'h3243f6a8885a308d313198a2e0370734;
    v_ek[2] = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    v_ex[2] = 128'h3925841d02dc09fbdc118597196a0b32;
    v_dd[0] = 128'h3925841d02dc09fbdc118597196a0b32;
    v_dk[0] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    v_dx[0] = 128'h3243f6a8885a308d313198a2e0370734;
    v_dd[2] = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    v_dk[2] = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    v_dx[2] = 128'h00112233445566778899aabbccddeeff;
    v_ed[1] = v_ed[0]; v_ek[1] = v_ek[0]; v_ex[1] = v_ex[0];
    v_ed[3] = v_ed[2]; v_ek[3] = v_ek[2]; v_ex[3] = v_ex[2];
    v_ed[4] = v_ed[0]; v_ek[4] = v_ek[0]; v_ex[4] = v_ex[0];
    v_dd[1] = v_dd[0]; v_dk[1] = v_dk[0]; v_dx[1] = v_dx[0];
    v_dd[3] = v_dd[2]; v_dk[3] = v_dk[2]; v_dx[3] = v_dx[2];
    v_dd[4] = v_dd[0]; v_dk[4] = v_dk[0]; v_dx[4] = v_dx[0];

    apply(0);
    #2;
    check_reset("reset_state");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Next inputs change while the current block is mid-flight
    for (int k = 0; k < N; k++) begin
      repeat (5) @(posedge clk);
      #1;
      if (k + 1 < N) apply(k + 1);
      repeat (7) @(posedge clk);
    end

    // Abort the following block around round 3
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1 check_reset("reset_mid");
    eq.push_back(v_ex[N-1]);
    dq.push_back(v_dx[N-1]);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (eq.size() != 0) begin
      errors++; $display("FAIL enc_pending got %0d want 0", eq.size());
    end
    checks++;
    if (dq.size() != 0) begin
      errors++; $display("FAIL dec_pending got %0d want 0", dq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes128_core.md
# aes128_core

Iterative AES-128 block engine, one round per clock, that free-runs: it captures a 128-bit block and key, runs 10 rounds, publishes the result with a one-cycle `finished` pulse, then immediately captures the next block. Direction (cipher or inverse cipher) is fixed at elaboration by a parameter. It is the datapath core under the bus/IP wrapper. The wrapper is responsible for holding `data_in`/`key` stable across the capture cycle.

## Interface
- `DECRYPT`, default 0: 0 selects FIPS-197 Cipher; 1 selects Inverse Cipher. With 1, `key` is the final (round-10) round key, not the cipher key.
- `clk` input 1: single clock, rising-edge.
- `rst_n` input 1: asynchronous, active-high reset. The port keeps the codebase name; it is asserted when high.
- `data_in` input 128: plaintext (ciphertext when `DECRYPT`=1); bit 127 is byte 0 of the FIPS state.
- `key` input 128: round-key seed, same byte ordering as `data_in`.
- `data_out` output 128: registered result of the last completed block.
- `finished` output 1: registered, high for exactly one cycle when `data_out` updates.

## Operation
- States: LOAD, ROUND (counter 1..10), DONE. Cycle: LOAD → ROUND×10 → DONE → LOAD.
- LOAD:
  - Sample `data_in` and `key`.
  - Set state = `data_in` XOR `key` (AddRoundKey round 0).
  - Set key register = `key`.
  - Set round counter = 1.
- ROUND r, encrypt (`DECRYPT`=0):
  - Derive next round key on the fly using RotWord, SubWord, Rcon[r]; Rcon = 01,02,04,08,10,20,40,80,1b,36.
  - Apply SubBytes, ShiftRows, MixColumns, AddRoundKey.
  - Round 10 omits MixColumns.
- ROUND r, decrypt (`DECRYPT`=1):
  - Derive previous round key by the inverse schedule: w[i-4] = w[i] XOR w[i-1] for non-first words; first word uses SubWord(RotWord(w[i-1])) XOR Rcon[11-r].
  - Apply InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns.
  - Round 10 omits InvMixColumns and ends with the original cipher key.
- DONE:
  - Write the final state to `data_out`.
  - Pulse `finished`.
  - Next state is LOAD.
- `data_in`/`key` are ignored outside LOAD. Changes mid-block affect only the next block.
- `data_out` holds its value between DONE cycles.
- S-box and inverse S-box are combinational lookup tables or composite-field logic; either is acceptable.

## Timing
- Reset asserted:
  - Outputs go 0 immediately (`data_out` = 0, `finished` = 0).
  - FSM goes to LOAD; counter and internal registers go 0.
- Reset mid-block aborts the block with no `finished`. LOAD occurs on the first rising edge after release.
- First rising edge after release = LOAD, rounds 1..10 on the next 10 edges, and DONE on the 12th edge.
- `data_out` and `finished` become valid after the 12th edge.
- Latency: 12 cycles from capture edge to result. Throughput: one block per 12 cycles; LOAD follows DONE with no idle gap.
- `finished` high for one cycle every 12 cycles; never two consecutive cycles.

## Test plan
- Encrypt, `DECRYPT`=0, `data_in`=00112233445566778899aabbccddeeff, `key`=000102030405060708090a0b0c0d0e0f:
  - Required: `data_out`=69c4e0d86a7b0430d8cdb78070b4c55a with `finished` pulse on cycle 12 after reset release.
- Encrypt, `data_in`=3243f6a8885a308d313198a2e0370734, `key`=2b7e151628aed2a6abf7158809cf4f3c, applied before LOAD:
  - Required: `data_out`=3925841d02dc09fbdc118597196a0b32.
- Decrypt, `DECRYPT`=1, `data_in`=3925841d02dc09fbdc118597196a0b32, `key`=d014f9a8c9ee2589e13f0cc8b6630ca6:
  - Required: `data_out`=3243f6a8885a308d313198a2e0370734.
- Free-running check, either mode, inputs held constant:
  - Required: `finished` pulses exactly every 12 cycles, each pulse one cycle wide, with an identical `data_out` each time.
- Mid-block input change, inputs changed during ROUND 5:
  - Required: the current result reflects the old inputs; the next result reflects the new inputs.
- Reset mid-block, assert `rst_n` (high) during ROUND 3:
  - Required: `data_out`=0 and `finished`=0 immediately; no pulse for the aborted block.
  - Required: after release, the first `finished` arrives 12 cycles later with the correct result.
